// File: rtl/mux16_sched_pkg.sv
// Shared constants and types for the 16-way round-robin scheduler.
// Imported by the interface, the picker and the top.
package mux16_sched_pkg;

  localparam int N_REQ = 16;
  localparam int DW    = 33;
  localparam int SW    = $clog2(N_REQ);

  typedef logic [SW-1:0] sel_t;
  typedef logic [DW-1:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/mux16_rr_scheduler_if.sv
// Requester-side and consumer-side handshake bundle.
// master = scheduler, slave = sources/consumer.
interface mux16_rr_scheduler_if;
  import mux16_sched_pkg::*;

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_mask;
  logic [N_REQ-1:0] req_ready;
  word_t [N_REQ-1:0] req_data;

  logic  out_valid;
  logic  out_last;
  logic  out_ready;
  word_t out_data;
  sel_t  out_src;

  modport master (
    input  req_valid,
    input  req_last,
    input  req_mask,
    input  req_data,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_src
  );

  modport slave (
    output req_valid,
    output req_last,
    output req_mask,
    output req_data,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_src
  );

endinterface

// File: rtl/mux16_rr_scheduler_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr.
// Purely combinational, wraps from the top index back to 0.
module rr_pick
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             idx,
  output logic             any
);

  sel_t c;

  always_comb begin
    any = 1'b0;
    idx = ptr;
    c   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      c = ptr + sel_t'(i);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Packet-locked round-robin 16:1 scheduler with a one-entry
// registered output stage.
module mux16_rr_scheduler
  import mux16_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mux16_rr_scheduler_if.master bus,
  output sel_t                sel,
  output logic                busy
);

  state_t state;
  sel_t   ptr;
  sel_t   lock_idx;
  sel_t   sel_q;
  sel_t   win;
  logic   any;
  logic   grant;
  logic   free;
  logic   beat_last;
  word_t  beat;
  logic [N_REQ-1:0] cand;

  assign cand = bus.req_valid & bus.req_mask;
  assign busy = (state == LOCKED);

  rr_pick u_pick (
    .req (cand),
    .ptr (ptr),
    .idx (win),
    .any (any)
  );

  always_comb begin
    free  = !bus.out_valid || bus.out_ready;
    grant = 1'b0;
    sel   = sel_q;
    case (state)
      IDLE: begin
        if (any && free && !rst) begin
          grant = 1'b1;
          sel   = win;
        end
      end
      LOCKED: begin
        // mask is deliberately ignored for the lock holder
        sel   = lock_idx;
        grant = free && bus.req_valid[lock_idx] && !rst;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[sel] = 1'b1;
  end

  assign beat      = bus.req_data[sel];
  assign beat_last = bus.req_last[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      lock_idx      <= '0;
      sel_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_src   <= '0;
    end else begin
      sel_q <= sel;
      if (grant) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= beat;
        bus.out_last  <= beat_last;
        bus.out_src   <= sel;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (grant && beat_last) begin
        state <= IDLE;
        ptr   <= sel + sel_t'(1);
      end else if (grant) begin
        state    <= LOCKED;
        lock_idx <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Scoreboard bench for the 16-way round-robin scheduler.
// Each task drives one scenario and checks inline.
module tb_mux16_rr_scheduler;
  import mux16_sched_pkg::*;

  typedef struct packed {
    sel_t  src;
    word_t data;
    logic  last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sel_t sel;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  beat_t sb[$];

  mux16_rr_scheduler_if bus();

  mux16_rr_scheduler dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sel  (sel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic word_t mk(int k, int b);
    return {1'b1, 8'(k), 24'(b) ^ 24'h5A5A5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_mask  = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // single beat from k alone, leaves ptr at k+1
  task automatic one_beat(int k);
    bus.req_valid    = '0;
    bus.req_valid[k] = 1'b1;
    bus.req_last[k]  = 1'b1;
    bus.req_data[k]  = mk(k, 99);
    tick();
    quiet();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_last !== 1'b0 || bus.out_src !== '0 ||
        sel !== '0 || busy !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_vals: v=%b d=%h l=%b src=%0d sel=%0d busy=%b rdy=%h want all 0",
        bus.out_valid, bus.out_data, bus.out_last, bus.out_src, sel, busy, bus.req_ready);
    end
    tick();
    one_beat(9);
    bus.req_valid[3] = 1'b1;
    bus.req_data[3]  = mk(3, 0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 16'h0008) begin
      errors++;
      $display("FAIL rst_beat0: rdy=%h want 0008", bus.req_ready);
    end
    tick();
    bus.req_data[3] = mk(3, 1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.req_ready !== 16'h0008 || bus.out_data !== mk(3, 0)) begin
      errors++;
      $display("FAIL rst_beat1: busy=%b rdy=%h d=%h want 1 0008 %h",
        busy, bus.req_ready, bus.out_data, mk(3, 0));
    end
    tick();
    bus.req_data[3] = mk(3, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || sel !== '0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL rst_mid: v=%b busy=%b sel=%0d rdy=%h want 0 0 0 0",
        bus.out_valid, busy, sel, bus.req_ready);
    end
    tick();
    bus.req_valid[3]  = 1'b1;
    bus.req_last[3]   = 1'b1;
    bus.req_data[3]   = mk(3, 7);
    bus.req_valid[12] = 1'b1;
    bus.req_last[12]  = 1'b1;
    bus.req_data[12]  = mk(12, 7);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 16'h0008 || sel !== sel_t'(3)) begin
      errors++;
      $display("FAIL rst_rearb: rdy=%h sel=%0d want 0008 3", bus.req_ready, sel);
    end
    tick();
    quiet();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== sel_t'(3) ||
        bus.out_data !== mk(3, 7) || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL rst_out: v=%b src=%0d d=%h l=%b want 1 3 %h 1",
        bus.out_valid, bus.out_src, bus.out_data, bus.out_last, mk(3, 7));
    end
    tick();
  endtask

  task automatic test_fairness();
    beat_t e;
    do_reset();
    bus.req_valid = '1;
    bus.req_last  = '1;
    for (int k = 0; k < N_REQ; k++) bus.req_data[k] = mk(k, 0);
    for (int c = 0; c <= 17; c++) begin
      if (c == 17) bus.req_valid = '0;
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL fair_out c=%0d: scoreboard empty", c);
        end else begin
          e = sb.pop_front();
          if (bus.out_valid !== 1'b1 || bus.out_src !== e.src ||
              bus.out_data !== e.data || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL fair_out c=%0d: got v=%b src=%0d d=%h want src=%0d d=%h",
              c, bus.out_valid, bus.out_src, bus.out_data, e.src, e.data);
          end
        end
      end
      if (c <= 16) begin
        checks++;
        if (sel !== sel_t'(c % 16) || bus.req_ready !== 16'(1 << (c % 16))) begin
          errors++;
          $display("FAIL fair_grant c=%0d: sel=%0d rdy=%h want %0d %h",
            c, sel, bus.req_ready, c % 16, 16'(1 << (c % 16)));
        end
        sb.push_back(beat_t'{sel_t'(c % 16), mk(c % 16, 0), 1'b1});
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_packet_lock();
    sel_t order [6] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd9, 4'd2};
    beat_t e;
    do_reset();
    one_beat(4);
    for (int c = 0; c <= 6; c++) begin
      bus.req_valid = '0;
      if (c < 4) bus.req_valid[5] = 1'b1;
      if (c < 5) bus.req_valid[9] = 1'b1;
      if (c < 6) bus.req_valid[2] = 1'b1;
      bus.req_last[5] = (c == 3);
      bus.req_last[9] = 1'b1;
      bus.req_last[2] = 1'b1;
      bus.req_data[5] = mk(5, c);
      bus.req_data[9] = mk(9, 0);
      bus.req_data[2] = mk(2, 0);
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL lock_out c=%0d: scoreboard empty", c);
        end else begin
          e = sb.pop_front();
          if (bus.out_valid !== 1'b1 || bus.out_src !== e.src ||
              bus.out_data !== e.data || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL lock_out c=%0d: got src=%0d d=%h l=%b want src=%0d d=%h l=%b",
              c, bus.out_src, bus.out_data, bus.out_last, e.src, e.data, e.last);
          end
        end
      end
      if (c < 6) begin
        checks++;
        if (bus.req_ready !== (16'h1 << order[c]) || busy !== (c >= 1 && c <= 3)) begin
          errors++;
          $display("FAIL lock_grant c=%0d: rdy=%h busy=%b want %h %b",
            c, bus.req_ready, busy, 16'h1 << order[c], (c >= 1 && c <= 3));
        end
        sb.push_back(beat_t'{order[c],
          (order[c] == sel_t'(5)) ? mk(5, c) : mk(int'(order[c]), 0),
          (order[c] != sel_t'(5)) || (c == 3)});
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_backpressure();
    beat_t e;
    do_reset();
    bus.out_ready    = 1'b0;
    bus.req_valid[1] = 1'b1;
    bus.req_last[1]  = 1'b1;
    bus.req_data[1]  = 33'h1_DEAD_BEEF;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 16'h0002) begin
      errors++;
      $display("FAIL bp_load: rdy=%h want 0002", bus.req_ready);
    end
    sb.push_back(beat_t'{sel_t'(1), 33'h1_DEAD_BEEF, 1'b1});
    tick();
    bus.req_data[1] = mk(1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== '0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 33'h1_DEAD_BEEF || bus.out_src !== sel_t'(1)) begin
        errors++;
        $display("FAIL bp_hold i=%0d: rdy=%h v=%b d=%h src=%0d want 0 1 1deadbeef 1",
          i, bus.req_ready, bus.out_valid, bus.out_data, bus.out_src);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 16'h0002) begin
      errors++;
      $display("FAIL bp_release: rdy=%h want 0002", bus.req_ready);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bp_out0: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_src !== e.src) begin
        errors++;
        $display("FAIL bp_out0: v=%b d=%h want 1 %h", bus.out_valid, bus.out_data, e.data);
      end
    end
    sb.push_back(beat_t'{sel_t'(1), mk(1, 1), 1'b1});
    tick();
    quiet();
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bp_out1: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_src !== e.src) begin
        errors++;
        $display("FAIL bp_out1: v=%b d=%h want 1 %h", bus.out_valid, bus.out_data, e.data);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== mk(1, 1)) begin
      errors++;
      $display("FAIL bp_drain: v=%b d=%h want 0 %h", bus.out_valid, bus.out_data, mk(1, 1));
    end
    tick();
  endtask

  task automatic test_mask_wrap();
    beat_t e;
    sel_t  x;
    do_reset();
    one_beat(14);
    bus.req_valid   = 16'h8001;
    bus.req_last    = 16'h8001;
    bus.req_mask    = 16'h0001;
    bus.req_data[0]  = mk(0, 0);
    bus.req_data[15] = mk(15, 0);
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) bus.req_mask = '1;
      if (c == 4) quiet();
      x = (c == 2) ? sel_t'(15) : sel_t'(0);
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL wrap_out c=%0d: scoreboard empty", c);
        end else begin
          e = sb.pop_front();
          if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data) begin
            errors++;
            $display("FAIL wrap_out c=%0d: src=%0d d=%h want %0d %h",
              c, bus.out_src, bus.out_data, e.src, e.data);
          end
        end
      end
      if (c < 4) begin
        checks++;
        if (bus.req_ready !== (16'h1 << x) || sel !== x) begin
          errors++;
          $display("FAIL wrap_grant c=%0d: rdy=%h sel=%0d want %h %0d",
            c, bus.req_ready, sel, 16'h1 << x, x);
        end
        sb.push_back(beat_t'{x, mk(int'(x), 0), 1'b1});
      end
      tick();
    end
  endtask

  task automatic test_mask_midlock();
    beat_t e;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      bus.req_valid[7] = (c <= 4);
      bus.req_last[7]  = (c >= 2);
      bus.req_data[7]  = mk(7, c);
      if (c == 1) bus.req_mask[7] = 1'b0;
      if (c == 4) begin
        bus.req_valid[3] = 1'b1;
        bus.req_last[3]  = 1'b1;
        bus.req_data[3]  = mk(3, 0);
      end
      if (c == 5) bus.req_valid[3] = 1'b0;
      @(negedge clk);
      if (c > 0 && c != 4) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL midlock_out c=%0d: scoreboard empty", c);
        end else begin
          e = sb.pop_front();
          if (bus.out_valid !== 1'b1 || bus.out_src !== e.src ||
              bus.out_data !== e.data || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL midlock_out c=%0d: src=%0d d=%h l=%b want %0d %h %b",
              c, bus.out_src, bus.out_data, bus.out_last, e.src, e.data, e.last);
          end
        end
      end
      if (c <= 2) begin
        checks++;
        if (bus.req_ready !== 16'h0080) begin
          errors++;
          $display("FAIL midlock_grant c=%0d: rdy=%h want 0080", c, bus.req_ready);
        end
        sb.push_back(beat_t'{sel_t'(7), mk(7, c), c == 2});
      end else if (c == 3) begin
        checks++;
        if (bus.req_ready !== '0 || sel !== sel_t'(7)) begin
          errors++;
          $display("FAIL midlock_excl: rdy=%h sel=%0d want 0 7", bus.req_ready, sel);
        end
      end else if (c == 4) begin
        checks++;
        if (bus.req_ready !== 16'h0008 || bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL midlock_next: rdy=%h v=%b want 0008 0", bus.req_ready, bus.out_valid);
        end
        sb.push_back(beat_t'{sel_t'(3), mk(3, 0), 1'b1});
      end
      tick();
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_mask_wrap();
    test_mask_midlock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Round-robin scheduler sharing one 16:1, 33-bit output path among 16 requesters.
- Each requester presents data with valid/last; the block arbitrates and drives the 4-bit select. It forwards the granted beat through a one-entry output register using a valid/ready handshake.
- Grants are packet-locked: a winner keeps the path until its last beat is accepted.
- Sits between the requester sources and the downstream consumer of the muxed word.

Parameters:
- N_REQ, 16, number of requesters (fixed by 16:1 datapath).
- DW, 33, data width per requester.
- SW, 4, select width, equal to clog2(N_REQ).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_data  in  N_REQ x DW  packed per-requester data.
- req_mask  in  N_REQ  1 = requester eligible for new arbitration.
- req_ready  out  N_REQ  one-hot; the beat of requester k is accepted when req_valid[k] & req_ready[k].
- sel  out  SW  current mux select (index of locked/winning requester).
- out_valid  out  1  output register holds a beat.
- out_data  out  DW  registered beat.
- out_last  out  1  registered last flag.
- out_src  out  SW  requester index of the registered beat.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- busy  out  1  high while in LOCKED state.

Behaviour:
- Reset values, applied on the clk edge where rst=1:
  - out_valid=0, out_data=0, out_last=0, out_src=0, sel=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - rst overrides every other event. An in-flight beat or partial packet is dropped, with no recovery.
- Output slot is free when !out_valid or (out_valid & out_ready).
- FSM IDLE:
  - Candidates = req_valid & req_mask.
  - Winner = first candidate scanning ptr, ptr+1, ... wrapping 15->0.
  - Winner search and req_ready are combinational, same cycle.
  - If any candidate and slot is free: req_ready[winner]=1, sel=winner, beat loaded on the edge.
  - If that beat has last=1: stay IDLE, ptr <= winner+1 mod 16.
  - Else: go to LOCKED, lock_idx <= winner.
  - No candidate or slot not free: req_ready=0 and sel holds its last value.
- FSM LOCKED:
  - sel=lock_idx. Only req_ready[lock_idx] may assert, when slot free and req_valid[lock_idx].
  - req_mask is ignored for the locked requester; mask affects new arbitration only.
  - Accepting a beat with last=1 returns to IDLE with ptr <= lock_idx+1 mod 16.
  - Gaps (req_valid low) keep the lock; other requesters are starved until last.
- Latency and throughput:
  - A beat accepted at edge N is visible on out_* from edge N to N+1 onward.
  - Throughput is 1 beat/cycle with out_ready held high.
- Output register:
  - If out_valid & !out_ready, out_* is held stable and req_ready is all 0 (backpressure).
  - Drain and load in the same cycle are allowed; the register is replaced, with no bubble.
  - If drained with nothing loaded, out_valid <= 0; out_data holds its stale value.
- Simultaneous events: a requester whose valid rises in the same cycle as a packet end is arbitrated next cycle against the updated ptr.
- Wrap-around: ptr=15 and winner 15 gives ptr <= 0.
- Invariant: req_ready is at most one-hot and is never asserted while backpressured.

Decomposition:
- Package mux16_sched_pkg holds:
  - N_REQ, DW, SW constants.
  - typedef sel_t (logic [SW-1:0]) and typedef word_t (logic [DW-1:0]).
  - enum state_t {IDLE, LOCKED}.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: N_REQ request vector and ptr.
  - Outputs: winner index and any-valid flag.
  - Reused by other arbiters in the design.
- Top holds the FSM, ptr, lock_idx and the output register.

Test Plan:
- Reset: drive rst=1 mid-packet from requester 3 (2 of 4 beats sent) → next cycle out_valid=0, busy=0, sel=0, ptr=0. Requester 3 re-arbitrates from IDLE.
- Fairness: req_valid=16'hFFFF, all single-beat (last=1), out_ready=1 → grants 0,1,...,15,0 on consecutive cycles; out_src follows one cycle later.
- Packet lock: requester 5 sends 4 beats (last on 4th) while 2 and 9 request single beats → order 5,5,5,5,9,2. busy is high for beats 1-3, and ptr=6 after the packet.
- Backpressure: out_ready=0 for 3 cycles with data 33'h1_DEAD_BEEF loaded → out_data stable, req_ready=0 throughout. On release, the next beat loads the same cycle and out_valid stays 1.
- Mask/wrap: ptr=15 with req_valid=16'h8001 and req_mask=16'h0001 → requester 0 granted, 15 never. Then mask=16'hFFFF with ptr=1 and the same requests → 15 granted before 0.
- Mask mid-lock: clear req_mask[7] during 3-beat packet of requester 7 → all 3 beats forwarded, then 7 excluded from the next arbitration.
